// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the write-master state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Normal non-cacheable bufferable memory attributes.
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_REJ
  } wr_state_t;

endpackage

// File: rtl/axi_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) with master and slave views.
interface axi_write_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [ID_W-1:0]   wid;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wid, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wid, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_check.sv
// Combinational legality check of an AXI4 (burst, len) pair; shared by read and write masters.
module axi_burst_check
  import axi_pkg::*;
(
  input  logic [1:0] burst,
  input  logic [7:0] len,
  output logic       legal
);

  // WRAP bursts must be 2, 4, 8 or 16 beats; encoding 11 is reserved.
  always_comb begin
    legal = 1'b1;
    case (burst)
      BURST_WRAP: legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      2'b11:      legal = 1'b0;
      default:    legal = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_write_master.sv
// AXI4 write initiator: one command in, AW then len+1 W beats then one B, reported as a done pulse.
module axi_write_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [ID_W-1:0]   cmd_id,

  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,

  axi_write_master_if.master m_axi,

  output logic              done_valid,
  output logic [1:0]        done_resp,
  output logic              done_id_err,
  output logic              busy
);

  wr_state_t         state, state_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [7:0]        lat_len;
  logic [2:0]        lat_size;
  logic [1:0]        lat_burst;
  logic [ID_W-1:0]   lat_id;
  logic [7:0]        beat_cnt;

  logic burst_legal;
  logic aw_valid, w_valid, w_last, b_ready;
  logic cmd_hs, aw_hs, w_hs, b_hs;

  axi_burst_check u_burst_check (
    .burst (cmd_burst),
    .len   (cmd_len),
    .legal (burst_legal)
  );

  assign cmd_hs = cmd_valid & cmd_ready;
  assign aw_hs  = aw_valid & m_axi.awready;
  assign w_hs   = w_valid & m_axi.wready;
  assign b_hs   = b_ready & m_axi.bvalid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The done pulse is shown in IDLE, so command acceptance waits for it to clear.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    wr_ready  = 1'b0;
    w_last    = 1'b0;
    b_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = ~done_valid;
        if (cmd_valid && !done_valid) state_nxt = burst_legal ? ST_ADDR : ST_REJ;
      end
      ST_ADDR: begin
        aw_valid = 1'b1;
        if (m_axi.awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_valid  = wr_valid;
        wr_ready = m_axi.wready;
        w_last   = (beat_cnt == lat_len);
        if (wr_valid && m_axi.wready && w_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        b_ready = 1'b1;
        if (m_axi.bvalid) state_nxt = ST_IDLE;
      end
      ST_REJ:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr    <= '0;
      lat_len     <= '0;
      lat_size    <= '0;
      lat_burst   <= '0;
      lat_id      <= '0;
      beat_cnt    <= '0;
      done_valid  <= 1'b0;
      done_resp   <= RESP_OKAY;
      done_id_err <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      if (cmd_hs) begin
        lat_addr  <= cmd_addr;
        lat_len   <= cmd_len;
        lat_size  <= cmd_size;
        lat_burst <= cmd_burst;
        lat_id    <= cmd_id;
        if (!burst_legal) begin
          done_valid  <= 1'b1;
          done_resp   <= RESP_SLVERR;
          done_id_err <= 1'b0;
        end
      end
      if (aw_hs)     beat_cnt <= '0;
      else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
      if (b_hs) begin
        done_valid  <= 1'b1;
        done_resp   <= m_axi.bresp;
        done_id_err <= (m_axi.bid != lat_id);
      end
    end
  end

  assign m_axi.awaddr  = lat_addr;
  assign m_axi.awlen   = lat_len;
  assign m_axi.awsize  = lat_size;
  assign m_axi.awburst = lat_burst;
  assign m_axi.awid    = lat_id;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AWCACHE_DEFAULT;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = aw_valid;

  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = wr_strb;
  assign m_axi.wid     = lat_id;
  assign m_axi.wlast   = w_last;
  assign m_axi.wvalid  = w_valid;

  assign m_axi.bready  = b_ready;

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_axi_write_master.sv
// Directed, table-driven bench for axi_write_master with a simple in-bench AXI slave.
module tb_axi_write_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic [11:0] cmd_id = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        done_valid;
  logic [1:0]  done_resp;
  logic        done_id_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axi_write_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(12)) m_axi ();

  axi_write_master #(.ADDR_W(32), .DATA_W(32), .ID_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .cmd_size    (cmd_size),
    .cmd_burst   (cmd_burst),
    .cmd_id      (cmd_id),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .m_axi       (m_axi),
    .done_valid  (done_valid),
    .done_resp   (done_resp),
    .done_id_err (done_id_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  burst;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [11:0] id;
    logic [1:0]  bresp;
    logic [11:0] bid;
    bit          early_b;
    logic [1:0]  exp_resp;
    bit          exp_err;
    bit          exp_rej;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One command plus a cycle-by-cycle slave; abort_at>=0 returns mid-burst without final checks.
  task automatic runTxn(input string name, input logic [1:0] burst, input logic [7:0] len,
                        input logic [31:0] addr, input logic [11:0] id, input logic [1:0] r_bresp,
                        input logic [11:0] r_bid, input bit early_b, input int aw_stall,
                        input bit toggle, input int gap_at, input int abort_at,
                        input logic [1:0] exp_resp, input bit exp_err, input bit exp_rej,
                        input int exp_lat);
    int cyc = 0, beats = 0, aw_hs = 0, gap_cnt = 0, done_cyc = -1;
    int v_aw = 0, v_wpre = 0, v_bpre = 0, v_last = 0, v_data = 0;
    bit aw_done = 0, done_seen = 0, cr_in_done = 1;
    logic [1:0] got_resp = 2'bxx;
    logic got_err = 1'bx;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_size = 3'd2;
    cmd_burst = burst; cmd_id = id;
    #1;
    checkOutput({name, ".cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      m_axi.awready = (cyc > aw_stall);
      m_axi.wready  = toggle ? (cyc % 2 == 1) : 1'b1;
      wr_valid = !(gap_at >= 0 && beats == gap_at && gap_cnt < 2);
      wr_data  = 32'hA500_0000 + beats;
      wr_strb  = 4'(beats) ^ 4'hF;
      if (beats == int'(len) + 1) begin
        m_axi.bvalid = 1'b1; m_axi.bid = r_bid; m_axi.bresp = r_bresp;
      end else if (early_b) begin
        m_axi.bvalid = 1'b1; m_axi.bid = ~id; m_axi.bresp = RESP_DECERR;
      end else begin
        m_axi.bvalid = 1'b0;
      end
      #1;
      if (gap_at >= 0 && beats == gap_at && !wr_valid) gap_cnt++;
      if (m_axi.awvalid &&
          (m_axi.awaddr != addr || m_axi.awlen != len || m_axi.awburst != burst ||
           m_axi.awid != id || m_axi.awsize != 3'd2 || m_axi.awcache != 4'b0011)) v_aw++;
      if ((m_axi.wvalid || wr_ready) && !aw_done) v_wpre++;
      if (m_axi.bready && beats != int'(len) + 1) v_bpre++;
      if (m_axi.wvalid) begin
        if (m_axi.wlast != (beats == int'(len))) v_last++;
        if (m_axi.wdata != wr_data || m_axi.wstrb != wr_strb || m_axi.wid != id ||
            wr_ready != m_axi.wready) v_data++;
        if (m_axi.wready) beats++;
      end
      if (m_axi.awvalid && m_axi.awready) begin
        aw_hs++;
        aw_done = 1;
      end
      if (done_valid) begin
        done_seen = 1; done_cyc = cyc; got_resp = done_resp;
        got_err = done_id_err; cr_in_done = cmd_ready;
      end
      if (abort_at >= 0 && beats == abort_at) return;
      if (!done_seen) @(posedge clk);
    end
    checkOutput({name, ".done_seen"}, {31'b0, done_seen}, 32'd1);
    if (exp_lat >= 0) checkOutput({name, ".latency"}, done_cyc, exp_lat);
    checkOutput({name, ".done_resp"}, {30'b0, got_resp}, {30'b0, exp_resp});
    checkOutput({name, ".done_id_err"}, {31'b0, got_err}, {31'b0, exp_err});
    checkOutput({name, ".aw_handshakes"}, aw_hs, exp_rej ? 0 : 1);
    checkOutput({name, ".beats"}, beats, exp_rej ? 0 : int'(len) + 1);
    checkOutput({name, ".aw_stable"}, v_aw, 0);
    checkOutput({name, ".w_before_aw"}, v_wpre, 0);
    checkOutput({name, ".early_bready"}, v_bpre, 0);
    checkOutput({name, ".wlast_pos"}, v_last, 0);
    checkOutput({name, ".w_passthru"}, v_data, 0);
    checkOutput({name, ".cmd_ready_in_done"}, {31'b0, cr_in_done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0; m_axi.bvalid = 1'b0;
    #1;
    checkOutput({name, ".done_one_cycle"}, {31'b0, done_valid}, 32'd0);
    checkOutput({name, ".cmd_ready_after"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    runTxn($sformatf("vec%0d", idx), v.burst, v.len, v.addr, v.id, v.bresp, v.bid, v.early_b,
           0, 1'b0, -1, -1, v.exp_resp, v.exp_err, v.exp_rej, v.exp_lat);
  endtask

  initial begin
    int v_rst;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0;
    m_axi.bvalid = 1'b0; m_axi.bid = '0; m_axi.bresp = '0;

    vecs[0] = '{BURST_INCR,  8'd3,   32'h0000_1000, 12'h005, RESP_OKAY,   12'h005, 1'b0, RESP_OKAY,   1'b0, 1'b0, 7};
    vecs[1] = '{BURST_FIXED, 8'd0,   32'h0000_0040, 12'h001, RESP_EXOKAY, 12'h001, 1'b0, RESP_EXOKAY, 1'b0, 1'b0, 4};
    vecs[2] = '{BURST_WRAP,  8'd7,   32'h0000_0120, 12'hABC, RESP_OKAY,   12'hABC, 1'b0, RESP_OKAY,   1'b0, 1'b0, 11};
    vecs[3] = '{2'b11,       8'd3,   32'h0000_2000, 12'h010, RESP_OKAY,   12'h010, 1'b0, RESP_SLVERR, 1'b0, 1'b1, 1};
    vecs[4] = '{BURST_WRAP,  8'd2,   32'h0000_3000, 12'h011, RESP_OKAY,   12'h011, 1'b0, RESP_SLVERR, 1'b0, 1'b1, 1};
    vecs[5] = '{BURST_INCR,  8'd3,   32'h0000_4000, 12'h005, RESP_SLVERR, 12'h007, 1'b0, RESP_SLVERR, 1'b1, 1'b0, 7};
    vecs[6] = '{BURST_INCR,  8'd1,   32'h0000_5000, 12'h0F0, RESP_OKAY,   12'h0F0, 1'b1, RESP_OKAY,   1'b0, 1'b0, 5};
    vecs[7] = '{BURST_INCR,  8'd255, 32'h0001_0000, 12'h123, RESP_OKAY,   12'h123, 1'b0, RESP_OKAY,   1'b0, 1'b0, 259};
    vecs[8] = '{BURST_WRAP,  8'd15,  32'h0000_6040, 12'h456, RESP_DECERR, 12'h456, 1'b0, RESP_DECERR, 1'b0, 1'b0, 19};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset.awvalid", {31'b0, m_axi.awvalid}, 32'd0);
    checkOutput("reset.wvalid", {31'b0, m_axi.wvalid}, 32'd0);
    checkOutput("reset.bready", {31'b0, m_axi.bready}, 32'd0);
    checkOutput("reset.done_valid", {31'b0, done_valid}, 32'd0);
    checkOutput("reset.done_id_err", {31'b0, done_id_err}, 32'd0);
    checkOutput("reset.done_resp", {30'b0, done_resp}, 32'd0);
    checkOutput("reset.busy", {31'b0, busy}, 32'd0);
    checkOutput("reset.cmd_ready", {31'b0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    runTxn("awstall", BURST_INCR, 8'd3, 32'h0000_7000, 12'h003, RESP_OKAY, 12'h003, 1'b0,
           5, 1'b0, -1, -1, RESP_OKAY, 1'b0, 1'b0, 12);
    runTxn("wtoggle", BURST_INCR, 8'd5, 32'h0000_8000, 12'h009, RESP_OKAY, 12'h009, 1'b0,
           0, 1'b1, 2, -1, RESP_OKAY, 1'b0, 1'b0, -1);

    runTxn("abort", BURST_INCR, 8'd7, 32'h0000_9000, 12'h00A, RESP_OKAY, 12'h00A, 1'b0,
           0, 1'b0, -1, 2, RESP_OKAY, 1'b0, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; m_axi.bvalid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst.awvalid", {31'b0, m_axi.awvalid}, 32'd0);
    checkOutput("midrst.wvalid", {31'b0, m_axi.wvalid}, 32'd0);
    checkOutput("midrst.bready", {31'b0, m_axi.bready}, 32'd0);
    checkOutput("midrst.done_valid", {31'b0, done_valid}, 32'd0);
    checkOutput("midrst.busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v_rst = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (done_valid || busy) v_rst++;
    end
    checkOutput("midrst.no_done", v_rst, 0);
    runTxn("postrst", BURST_INCR, 8'd3, 32'h0000_A000, 12'h00B, RESP_OKAY, 12'h00B, 1'b0,
           0, 1'b0, -1, -1, RESP_OKAY, 1'b0, 1'b0, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
